// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared raster constants and helpers for the video path. The timing
// generator and every draw_* stage import this package so that they all
// agree on the coordinate width and the 640x480@60 default mode.
//
// Contents:
//   COORD_W        width of the sx/sy coordinate buses
//   VGA_*          640x480@60 timing (800x525 total)
//   axis_total()   total length of one axis (active + porches + sync)
//   h_total()      horizontal total, in pixels
//   v_total()      vertical total, in lines
//   coord_fits()   true when an axis total can be counted in COORD_W bits
// -----------------------------------------------------------------------------
package vga_pkg;

    // Coordinate width shared by the timing generator and all draw stages.
    localparam int COORD_W = 10;

    // Horizontal timing for 640x480@60, in pixels.
    localparam int VGA_H_RES  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    // Vertical timing for 640x480@60, in lines.
    localparam int VGA_V_RES  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    // Both sync pulses are active-low in this mode.
    localparam bit VGA_H_POL = 1'b0;
    localparam bit VGA_V_POL = 1'b0;

    // One axis is laid out as active region, front porch, sync, back porch.
    function automatic int axis_total(input int res, input int fp,
                                      input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    // Pixels per line including blanking.
    function automatic int h_total(input int res, input int fp,
                                   input int sync, input int bp);
        return axis_total(res, fp, sync, bp);
    endfunction

    // Lines per frame including blanking.
    function automatic int v_total(input int res, input int fp,
                                   input int sync, input int bp);
        return axis_total(res, fp, sync, bp);
    endfunction

    // A counter of COORD_W bits must be able to reach total-1.
    function automatic bit coord_fits(input int total);
        return (total >= 1) && (total <= (1 << COORD_W));
    endfunction

endpackage : vga_pkg

// File: rtl/vga_axis_timer.sv
// -----------------------------------------------------------------------------
// vga_axis_timer
//
// One axis of the raster: a position counter that runs 0..TOTAL-1 and wraps,
// plus the registered decode of that position (active region, sync level,
// terminal position). The timing generator uses one instance per axis.
//
// Parameters:
//   RES, FP, SYNC, BP   active length, front porch, sync width, back porch
//   POL                 sync output level while inside the sync interval
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset; parks pos at TOTAL-1
//   step        advance one position on this clock edge
//   pos         current position
//   active      pos < RES
//   sync        POL inside the sync interval, ~POL elsewhere
//   wrap        pos == TOTAL-1 (the next step returns to 0)
//   active_nxt  value active will take on the coming edge
// -----------------------------------------------------------------------------
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int RES  = VGA_H_RES,
    parameter int FP   = VGA_H_FP,
    parameter int SYNC = VGA_H_SYNC,
    parameter int BP   = VGA_H_BP,
    parameter bit POL  = VGA_H_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] pos,
    output logic               active,
    output logic               sync,
    output logic               wrap,
    output logic               active_nxt
);

    localparam int TOTAL      = axis_total(RES, FP, SYNC, BP);
    localparam int SYNC_START = RES + FP;
    localparam int SYNC_END   = RES + FP + SYNC;
    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    logic [COORD_W-1:0] pos_q;
    logic [COORD_W-1:0] pos_d;
    logic               active_q;
    logic               active_d;
    logic               sync_q;
    logic               sync_d;
    logic               wrap_q;
    logic               wrap_d;

    // Next position. The wrap flag is checked before incrementing, so the
    // counter never goes past TOTAL-1 and the adder cannot overflow.
    always_comb begin
        pos_d = pos_q;
        if (step) begin
            if (wrap_q) begin
                pos_d = '0;
            end else begin
                pos_d = pos_q + COORD_W'(1);
            end
        end
    end

    // Flags are decoded from the next position and registered together with
    // it, so pos and its flags always change on the same edge with no lag.
    // Comparisons are done in int so an interval ending exactly at
    // 2**COORD_W cannot be truncated.
    always_comb begin
        active_d = (int'(pos_d) < RES);
        sync_d   = ~POL;
        if ((int'(pos_d) >= SYNC_START) && (int'(pos_d) < SYNC_END)) begin
            sync_d = POL;
        end
        wrap_d = (pos_d == LAST);
    end

    // Reset parks the counter on its last position so that the first step
    // after release lands on 0. wrap is therefore set in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q    <= LAST;
            active_q <= 1'b0;
            sync_q   <= ~POL;
            wrap_q   <= 1'b1;
        end else begin
            pos_q    <= pos_d;
            active_q <= active_d;
            sync_q   <= sync_d;
            wrap_q   <= wrap_d;
        end
    end

    assign pos        = pos_q;
    assign active     = active_q;
    assign sync       = sync_q;
    assign wrap       = wrap_q;
    assign active_nxt = active_d;

endmodule : vga_axis_timer

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Raster timing generator feeding the draw_* stages. Produces the pixel
// coordinates and all sync/blanking/marker flags, advancing one pixel on each
// clock where pix_en is high. Every output is a register and every flag
// describes the sx/sy presented in the same cycle; downstream pipeline delay
// is the consumer's concern.
//
// Ports:
//   clk     system / pixel clock
//   rst_n   asynchronous active-low reset
//   pix_en  pixel strobe; the raster moves only on edges where it is high
//   sx      horizontal position, 0..H_TOTAL-1
//   sy      vertical position,   0..V_TOTAL-1
//   de      high inside the active picture (sx<H_RES and sy<V_RES)
//   hsync   H_POL while sx is inside the horizontal sync interval
//   vsync   V_POL for every line inside the vertical sync interval
//   line    high for the pixel period at sx==0
//   frame   high for the pixel period at sx==0, sy==0
// -----------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_RES  = VGA_H_RES,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_RES  = VGA_V_RES,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter bit H_POL  = VGA_H_POL,
    parameter bit V_POL  = VGA_V_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [COORD_W-1:0] sx,
    output logic [COORD_W-1:0] sy,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               line,
    output logic               frame
);

    localparam int H_TOTAL = h_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_RES, V_FP, V_SYNC, V_BP);

    // A mode whose totals do not fit the coordinate buses is rejected when
    // the design is elaborated rather than silently wrapping early.
    if (!coord_fits(H_TOTAL) || !coord_fits(V_TOTAL)) begin : g_total_too_wide
        $error("vga_timing: H_TOTAL and V_TOTAL must each be at most 1024");
    end

    logic [COORD_W-1:0] h_pos;
    logic               h_active;
    logic               h_sync;
    logic               h_wrap;
    logic               h_active_nxt;
    logic [COORD_W-1:0] v_pos;
    logic               v_active;
    logic               v_sync;
    logic               v_wrap;
    logic               v_active_nxt;
    logic               v_step;

    logic de_q;
    logic de_d;
    logic line_q;
    logic line_d;
    logic frame_q;
    logic frame_d;

    // Horizontal axis counts pixels.
    vga_axis_timer #(
        .RES  (H_RES),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .POL  (H_POL)
    ) u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (pix_en),
        .pos        (h_pos),
        .active     (h_active),
        .sync       (h_sync),
        .wrap       (h_wrap),
        .active_nxt (h_active_nxt)
    );

    // Vertical axis counts lines: it steps on the same edge that takes the
    // horizontal counter from its last pixel back to 0, so vsync changes
    // exactly at the start of a line.
    assign v_step = pix_en & h_wrap;

    vga_axis_timer #(
        .RES  (V_RES),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .POL  (V_POL)
    ) u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (v_step),
        .pos        (v_pos),
        .active     (v_active),
        .sync       (v_sync),
        .wrap       (v_wrap),
        .active_nxt (v_active_nxt)
    );

    // de, line and frame are registered so they change on the same edge as
    // sx/sy without a combinational AND on the output. On a pixel step they
    // take the decode of the position being entered; otherwise they follow
    // the current axis flags, which is the value they already hold. line and
    // frame mark the position entered when the horizontal counter wraps.
    always_comb begin
        de_d    = h_active & v_active;
        line_d  = line_q;
        frame_d = frame_q;
        if (pix_en) begin
            de_d    = h_active_nxt & v_active_nxt;
            line_d  = h_wrap;
            frame_d = h_wrap & v_wrap;
        end
    end

    // Reset clears the markers; the axis timers park on the last position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign sx    = h_pos;
    assign sy    = v_pos;
    assign de    = de_q;
    assign hsync = h_sync;
    assign vsync = v_sync;
    assign line  = line_q;
    assign frame = frame_q;

endmodule : vga_timing

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Directed bench for vga_timing. Two instances share one clock: the default
// 640x480@60 mode and a tiny 14x7 raster (H 8/2/2/2, V 4/1/1/1) whose whole
// frame can be walked end to end. Expected outputs come from the raster
// definition: a position model that steps x/y and a decode of a position
// into the seven outputs.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    // Default mode.
    localparam int H_RES = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_RES = 480, V_FP = 10, V_SYNC = 2,  V_BP = 33;
    localparam int H_TOT = 800, V_TOT = 525;

    // Small mode.
    localparam int SH_RES = 8, SH_FP = 2, SH_SYNC = 2, SH_BP = 2;
    localparam int SV_RES = 4, SV_FP = 1, SV_SYNC = 1, SV_BP = 1;
    localparam int SH_TOT = 14, SV_TOT = 7;

    // Reset state {sx, sy, de, hsync, vsync, line, frame}.
    localparam logic [24:0] RST_BIG   = {10'd799, 10'd524, 5'b01100};
    localparam logic [24:0] RST_SMALL = {10'd13,  10'd6,   5'b01100};

    logic       clk;
    logic       rst_n, pix_en;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync, line, frame;
    logic       rst_s_n, pix_s_en;
    logic [9:0] s_sx, s_sy;
    logic       s_de, s_hsync, s_vsync, s_line, s_frame;

    logic [24:0] obs, obs_s, expv;

    int compared;
    int mismatched;
    int mx, my;
    int nx, ny;

    assign obs   = {sx, sy, de, hsync, vsync, line, frame};
    assign obs_s = {s_sx, s_sy, s_de, s_hsync, s_vsync, s_line, s_frame};

    vga_timing dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en),
        .sx     (sx),
        .sy     (sy),
        .de     (de),
        .hsync  (hsync),
        .vsync  (vsync),
        .line   (line),
        .frame  (frame)
    );

    vga_timing #(
        .H_RES  (SH_RES), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
        .V_RES  (SV_RES), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP),
        .H_POL  (1'b0),   .V_POL (1'b0)
    ) dut_s (
        .clk    (clk),
        .rst_n  (rst_s_n),
        .pix_en (pix_s_en),
        .sx     (s_sx),
        .sy     (s_sy),
        .de     (s_de),
        .hsync  (s_hsync),
        .vsync  (s_vsync),
        .line   (s_line),
        .frame  (s_frame)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs expected at position (x,y) for an active-low sync mode.
    function automatic logic [24:0] exp_vec(input int x, input int y,
                                            input int hres, input int hfp, input int hsw,
                                            input int vres, input int vfp, input int vsw);
        logic d, h, v, l, f;
        d = (x < hres) && (y < vres);
        h = !((x >= hres + hfp) && (x < hres + hfp + hsw));
        v = !((y >= vres + vfp) && (y < vres + vfp + vsw));
        l = (x == 0);
        f = (x == 0) && (y == 0);
        return {10'(x), 10'(y), d, h, v, l, f};
    endfunction

    function automatic logic [24:0] exp_big(input int x, input int y);
        return exp_vec(x, y, H_RES, H_FP, H_SYNC, V_RES, V_FP, V_SYNC);
    endfunction

    function automatic logic [24:0] exp_small(input int x, input int y);
        return exp_vec(x, y, SH_RES, SH_FP, SH_SYNC, SV_RES, SV_FP, SV_SYNC);
    endfunction

    // Raster stepping: x wraps at its total, y steps when x wraps.
    function automatic int next_x(input int x, input int htot);
        return (x == htot - 1) ? 0 : x + 1;
    endfunction

    function automatic int next_y(input int x, input int y, input int htot, input int vtot);
        if (x != htot - 1) return y;
        return (y == vtot - 1) ? 0 : y + 1;
    endfunction

    // Reset values while held, then the first pixel after release.
    task automatic test_reset();
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (obs !== RST_BIG) begin
            mismatched++;
            $display("[TB] FAIL reset_default: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs[24:15], obs[14:5], obs[4:0], RST_BIG[24:15], RST_BIG[14:5], RST_BIG[4:0]);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mx = 0;
        my = 0;
        expv = {10'd0, 10'd0, 5'b11111};
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL first_pixel: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs[24:15], obs[14:5], obs[4:0], expv[24:15], expv[14:5], expv[4:0]);
        end
    endtask

    // One full line at full rate: de edge at 640, hsync low 656..751,
    // line marker returns after exactly 800 clocks.
    task automatic test_line_timing();
        int line_hits;
        int line_at;
        line_hits = 0;
        line_at   = -1;
        for (int i = 0; i < H_TOT; i++) begin
            @(posedge clk);
            #1;
            ny = next_y(mx, my, H_TOT, V_TOT);
            mx = next_x(mx, H_TOT);
            my = ny;
            expv = exp_big(mx, my);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL line_timing: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                         obs[24:15], obs[14:5], obs[4:0], expv[24:15], expv[14:5], expv[4:0]);
            end
            if (line === 1'b1) begin
                line_hits++;
                line_at = i;
            end
        end
        compared++;
        if (line_hits != 1 || line_at != H_TOT - 1) begin
            mismatched++;
            $display("[TB] FAIL line_period: got %0d markers last at clock %0d want 1 marker at clock %0d",
                     line_hits, line_at + 1, H_TOT);
        end
    endtask

    // pix_en high on every other clock: each value holds for two clocks and
    // the coordinate sequence matches the full-rate one.
    task automatic test_half_rate();
        for (int i = 0; i < 24; i++) begin
            pix_en = 1'b0;
            @(posedge clk);
            #1;
            expv = exp_big(mx, my);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL half_hold: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                         obs[24:15], obs[14:5], obs[4:0], expv[24:15], expv[14:5], expv[4:0]);
            end
            pix_en = 1'b1;
            @(posedge clk);
            #1;
            ny = next_y(mx, my, H_TOT, V_TOT);
            mx = next_x(mx, H_TOT);
            my = ny;
            expv = exp_big(mx, my);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL half_step: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                         obs[24:15], obs[14:5], obs[4:0], expv[24:15], expv[14:5], expv[4:0]);
            end
        end
    endtask

    // Reset asserted mid-line with pix_en high: reset values appear before
    // the next edge, and the raster restarts at (0,0) after release.
    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        compared++;
        if (obs !== RST_BIG) begin
            mismatched++;
            $display("[TB] FAIL reset_async: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs[24:15], obs[14:5], obs[4:0], RST_BIG[24:15], RST_BIG[14:5], RST_BIG[4:0]);
        end
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (obs !== RST_BIG) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs[24:15], obs[14:5], obs[4:0], RST_BIG[24:15], RST_BIG[14:5], RST_BIG[4:0]);
        end
        rst_n = 1'b1;
        mx = H_TOT - 1;
        my = V_TOT - 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            ny = next_y(mx, my, H_TOT, V_TOT);
            mx = next_x(mx, H_TOT);
            my = ny;
            expv = exp_big(mx, my);
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL restart: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                         obs[24:15], obs[14:5], obs[4:0], expv[24:15], expv[14:5], expv[4:0]);
            end
        end
    endtask

    // Small raster: reset values, then two full frames at full rate covering
    // hsync/vsync boundaries, the (13,6)->(0,0) wrap and the frame period.
    task automatic test_small_frames();
        int last_frame;
        logic prev_frame;
        compared++;
        if (obs_s !== RST_SMALL) begin
            mismatched++;
            $display("[TB] FAIL small_reset: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs_s[24:15], obs_s[14:5], obs_s[4:0], RST_SMALL[24:15], RST_SMALL[14:5], RST_SMALL[4:0]);
        end
        rst_s_n    = 1'b1;
        pix_s_en   = 1'b1;
        nx         = SH_TOT - 1;
        ny         = SV_TOT - 1;
        last_frame = -1;
        prev_frame = 1'b0;
        for (int i = 0; i <= 2 * SH_TOT * SV_TOT; i++) begin
            int ty;
            @(posedge clk);
            #1;
            ty = next_y(nx, ny, SH_TOT, SV_TOT);
            nx = next_x(nx, SH_TOT);
            ny = ty;
            expv = exp_small(nx, ny);
            compared++;
            if (obs_s !== expv) begin
                mismatched++;
                $display("[TB] FAIL small_run: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                         obs_s[24:15], obs_s[14:5], obs_s[4:0], expv[24:15], expv[14:5], expv[4:0]);
            end
            if (s_frame === 1'b1 && prev_frame !== 1'b1) begin
                if (last_frame >= 0) begin
                    compared++;
                    if (i - last_frame != SH_TOT * SV_TOT) begin
                        mismatched++;
                        $display("[TB] FAIL frame_period: got %0d steps want %0d",
                                 i - last_frame, SH_TOT * SV_TOT);
                    end
                end
                last_frame = i;
            end
            prev_frame = s_frame;
        end
    endtask

    // Small raster with an irregular strobe (one clock in three): outputs
    // hold between strobes and the sequence is unchanged.
    task automatic test_small_sparse();
        for (int i = 0; i < 90; i++) begin
            pix_s_en = (i % 3 == 0);
            @(posedge clk);
            #1;
            if (pix_s_en) begin
                int ty;
                ty = next_y(nx, ny, SH_TOT, SV_TOT);
                nx = next_x(nx, SH_TOT);
                ny = ty;
            end
            expv = exp_small(nx, ny);
            compared++;
            if (obs_s !== expv) begin
                mismatched++;
                $display("[TB] FAIL small_sparse: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                         obs_s[24:15], obs_s[14:5], obs_s[4:0], expv[24:15], expv[14:5], expv[4:0]);
            end
        end
    endtask

    // Back-to-back: reset the small raster mid-frame, release on the next
    // clock and check the restart at (0,0) with frame high.
    task automatic test_back_to_back();
        pix_s_en = 1'b1;
        rst_s_n  = 1'b0;
        #1;
        compared++;
        if (obs_s !== RST_SMALL) begin
            mismatched++;
            $display("[TB] FAIL small_reset_mid: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs_s[24:15], obs_s[14:5], obs_s[4:0], RST_SMALL[24:15], RST_SMALL[14:5], RST_SMALL[4:0]);
        end
        @(posedge clk);
        #1;
        rst_s_n = 1'b1;
        @(posedge clk);
        #1;
        expv = {10'd0, 10'd0, 5'b11111};
        compared++;
        if (obs_s !== expv) begin
            mismatched++;
            $display("[TB] FAIL small_restart: got sx=%0d sy=%0d flags=%b want sx=%0d sy=%0d flags=%b",
                     obs_s[24:15], obs_s[14:5], obs_s[4:0], expv[24:15], expv[14:5], expv[4:0]);
        end
    endtask

    // Test sequence; the small raster is held in reset until its turn.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        pix_en     = 1'b1;
        rst_s_n    = 1'b0;
        pix_s_en   = 1'b1;
        $display("[TB] vga_timing directed tests");
        test_reset();
        test_line_timing();
        test_half_rate();
        test_reset_mid();
        test_small_frames();
        test_small_sparse();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_vga_timing

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator directly upstream of the drawing stages (gradient, pattern, sprite).
- Produces the pixel coordinates sx/sy, the data-enable de, the hsync/vsync pulses and frame/line markers that every draw_* block consumes.
- Advances one pixel per clock on which pix_en is high, so it runs from the PLL clock with or without a divided pixel strobe.
- Defaults give 640x480@60 (800x525 total).

Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  input  1  system/pixel clock
- rst_n  input  1  asynchronous active-low reset
- pix_en  input  1  pixel strobe; counters advance only on clk edges where pix_en=1
- sx  output  10  current horizontal position, 0..H_TOTAL-1
- sy  output  10  current vertical position, 0..V_TOTAL-1
- de  output  1  high when sx<H_RES and sy<V_RES
- hsync  output  1  horizontal sync at H_POL level during the sync interval
- vsync  output  1  vertical sync at V_POL level during the sync interval
- line  output  1  high while sx==0
- frame  output  1  high while sx==0 and sy==0

Behaviour:
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP
- Widths: H_TOTAL and V_TOTAL must be ≤1024. Elaboration fails otherwise.
- Reset (async assert, sync release):
  - sx=H_TOTAL-1, sy=V_TOTAL-1 (parked at the last position).
  - de=0, line=0, frame=0.
  - hsync=~H_POL, vsync=~V_POL.
- Position update, on each clk edge with pix_en=1:
  - sx<H_TOTAL-1: sx+1, sy unchanged.
  - sx==H_TOTAL-1: sx=0. sy becomes sy+1, or 0 if sy==V_TOTAL-1.
  - Consequence: the first pix_en after reset release yields sx=0, sy=0, de=1, frame=1, line=1.
- pix_en=0: all outputs hold their values. No glitches, no pulses regenerated.
- Alignment:
  - All outputs are registers updated on the same edge.
  - de, hsync, vsync, line and frame always describe the sx/sy shown in the same cycle. There is zero latency between the coordinates and their flags.
  - Downstream stages add their own pipeline delay. This block does not compensate for it.
- hsync is active for H_RES+H_FP ≤ sx ≤ H_RES+H_FP+H_SYNC-1.
- vsync is active for V_RES+V_FP ≤ sy ≤ V_RES+V_FP+V_SYNC-1, for the whole of each such line (counted in whole lines, not offset within a line).
- line and frame are levels lasting one pixel period (one pix_en interval), not one clk.
- Reset mid-frame: outputs return to their reset values immediately. The sequence restarts cleanly at (0,0) on the first pix_en after release.
- No arithmetic overflow is possible. The compare-to-terminal wrap precedes any increment past H_TOTAL-1 / V_TOTAL-1.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants.
  - COORD_W=10.
  - The H_TOTAL/V_TOTAL derivation functions.
  - Also consumed by the draw_* blocks.
- One natural sub-module, vga_axis_timer, instantiated twice:
  - Parameters: RES, FP, SYNC, BP, POL.
  - Inputs: clk, rst_n, step.
  - Outputs: pos, active, sync, wrap.
  - The horizontal instance steps on pix_en. The vertical instance steps on pix_en & h.wrap.

Test Plan:
- Hold rst_n=0 for 5 clk with pix_en=1 → sx=799, sy=524, de=0, hsync=1, vsync=1, frame=0. Release, then one pix_en → sx=0, sy=0, de=1, frame=1, line=1.
- Free-run with pix_en=1 → de falls at sx=640. hsync=0 exactly for sx=656..751, rising at sx=752. 800 clocks per line.
- Run to sy=489 → vsync=0 for the whole of lines 490 and 491, and 1 at line 492. de=0 for sy≥480.
- Wrap check at (799,524) → next pixel is (0,0) with frame=1. Total 420000 pixel steps per frame, measured between frame rising edges.
- pix_en toggling 1-of-2 (25 MHz from 50 MHz) → each output holds 2 clk per pixel. Coordinate sequence is identical to the free-run case.
- Assert rst_n=0 at (300,200) with pix_en=1 → reset values appear before the next edge. Restart from (0,0) after release. Also repeat all checks with small parameters (H 8/2/2/2, V 4/1/1/1) for exhaustive coverage.
